// File: rtl/led_seq_ctrl_pkg.sv
// Shared encodings for the LED pattern sequencer and its command source.
// Mode encodings, FSM state type and bounce direction constants.
package led_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_RUN    = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_BLINK  = 2'd1,
    S_RUN    = 2'd2,
    S_BOUNCE = 2'd3
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_seq_ctrl_tick_gen.sv
// Time-base counter for the LED sequencer: synchronous clear and enable,
// wraps at CNT_MAX and flags the terminal count while enabled.
module tick_gen #(
  parameter int                 CNT_W   = 25,
  parameter logic [CNT_W-1:0]   CNT_MAX = 25'd24_999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_max_s;

  assign at_max_s = (cnt_q == CNT_MAX);
  // Clear wins over enable so an accept on the terminal count swallows the tick.
  assign tick     = at_max_s && en && !clr;

  // Next counter value: clear, wrap, increment or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en) begin
      if (at_max_s) begin
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED bank pattern sequencer: valid/ready mode commands select off, blink,
// running light or bounce, stepped by a shared time-base tick.
module led_seq_ctrl
  import led_seq_ctrl_pkg::*;
#(
  parameter int               CNT_W   = 25,
  parameter logic [CNT_W-1:0] CNT_MAX = 25'd24_999_999,
  parameter int               LED_W   = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_mode,
  output logic             cmd_ready,
  input  logic             hold,
  output logic             tick,
  output logic [LED_W-1:0] led_out
);

  localparam logic [LED_W-1:0] PAT_ZERO = {LED_W{1'b0}};
  localparam logic [LED_W-1:0] PAT_ONES = {LED_W{1'b1}};
  localparam logic [LED_W-1:0] PAT_BIT0 = {{(LED_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             ready_q, ready_d;

  logic accept_s;
  logic tg_clr_s;
  logic tg_en_s;
  logic tick_s;

  assign accept_s  = cmd_valid && ready_q;
  assign tg_clr_s  = accept_s || (state_q == S_OFF);
  assign tg_en_s   = !hold && (state_q != S_OFF);
  assign cmd_ready = ready_q;
  assign tick      = tick_s;
  assign led_out   = led_q;

  tick_gen #(
    .CNT_W   (CNT_W),
    .CNT_MAX (CNT_MAX)
  ) u_tick_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (tg_clr_s),
    .en        (tg_en_s),
    .tick      (tick_s)
  );

  // Next mode, direction and pattern; accept outranks the tick.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    led_d   = led_q;
    ready_d = !accept_s;
    if (accept_s) begin
      dir_d = DIR_UP;
      case (cmd_mode)
        MODE_OFF:    begin state_d = S_OFF;    led_d = PAT_ZERO; end
        MODE_BLINK:  begin state_d = S_BLINK;  led_d = PAT_ONES; end
        MODE_RUN:    begin state_d = S_RUN;    led_d = PAT_BIT0; end
        MODE_BOUNCE: begin state_d = S_BOUNCE; led_d = PAT_BIT0; end
        default:     begin state_d = S_OFF;    led_d = PAT_ZERO; end
      endcase
    end else if (tick_s) begin
      case (state_q)
        S_BLINK: led_d = ~led_q;
        S_RUN:   led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
        S_BOUNCE: begin
          // Flip direction as the lit bit lands on an end position.
          if (dir_q == DIR_UP) begin
            led_d = led_q << 1;
            if (led_q[LED_W-2]) begin
              dir_d = DIR_DOWN;
            end else begin
              dir_d = dir_q;
            end
          end else begin
            led_d = led_q >> 1;
            if (led_q[1]) begin
              dir_d = DIR_UP;
            end else begin
              dir_d = dir_q;
            end
          end
        end
        S_OFF:   led_d = PAT_ZERO;
        default: led_d = led_q;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Mode, direction, pattern and ready registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_OFF;
      dir_q   <= DIR_UP;
      led_q   <= PAT_ZERO;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed self-checking bench for led_seq_ctrl with CNT_MAX=3, LED_W=4.
module tb_led_seq_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       cmd_valid;
  logic [1:0] cmd_mode;
  logic       cmd_ready;
  logic       hold;
  logic       tick;
  logic [3:0] led_out;

  int n_chk  = 0;
  int n_fail = 0;

  led_seq_ctrl #(
    .CNT_W   (25),
    .CNT_MAX (25'd3),
    .LED_W   (4)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .cmd_valid (cmd_valid),
    .cmd_mode  (cmd_mode),
    .cmd_ready (cmd_ready),
    .hold      (hold),
    .tick      (tick),
    .led_out   (led_out)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Entered with the counter at 0; one full step period with no hold.
  task automatic period(input string tag, input logic [3:0] exp_led);
    chk({tag, "_t0"}, {31'd0, tick}, 32'd0);
    step();
    chk({tag, "_t1"}, {31'd0, tick}, 32'd0);
    step();
    chk({tag, "_t2"}, {31'd0, tick}, 32'd0);
    step();
    chk({tag, "_t3"}, {31'd0, tick}, 32'd1);
    step();
    chk({tag, "_led"}, {28'd0, led_out}, {28'd0, exp_led});
  endtask

  task automatic issue(input logic [1:0] mode);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    step();
    cmd_valid = 1'b0;
  endtask

  logic [3:0] bounce_seq [8];

  initial begin
    bounce_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
    sys_rst_n = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode  = 2'd0;
    hold      = 1'b0;
    #2 sys_rst_n = 1'b0;
    step();
    step();
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_led", {28'd0, led_out}, 32'd0);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    sys_rst_n = 1'b1;
    #1;
    chk("rel_ready_lo", {31'd0, cmd_ready}, 32'd0);
    step();
    chk("rel_ready_hi", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 50; i++) begin
      chk("idle_tick", {31'd0, tick}, 32'd0);
      chk("idle_led", {28'd0, led_out}, 32'd0);
      step();
    end

    // RUN: rotate left every 4 cycles
    issue(2'd2);
    chk("run_init", {28'd0, led_out}, 32'd1);
    chk("run_ready_lo", {31'd0, cmd_ready}, 32'd0);
    period("run1", 4'b0010);
    period("run2", 4'b0100);
    period("run3", 4'b1000);
    period("run4", 4'b0001);

    // BOUNCE
    issue(2'd3);
    chk("bnc_init", {28'd0, led_out}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      period("bnc", bounce_seq[i]);
    end

    // BLINK with a 5-cycle hold mid-period
    issue(2'd1);
    chk("blk_init", {28'd0, led_out}, 32'hF);
    period("blk1", 4'b0000);
    step();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_tick", {31'd0, tick}, 32'd0);
      step();
    end
    hold = 1'b0;
    chk("hold_led_frozen", {28'd0, led_out}, 32'd0);
    step();
    chk("hold_t2", {31'd0, tick}, 32'd0);
    step();
    chk("hold_t3", {31'd0, tick}, 32'd1);
    step();
    chk("hold_led_step", {28'd0, led_out}, 32'hF);

    // Hold on the terminal count suppresses the tick
    step();
    step();
    step();
    chk("tc_tick", {31'd0, tick}, 32'd1);
    hold = 1'b1;
    #1;
    chk("tc_hold_tick", {31'd0, tick}, 32'd0);
    step();
    chk("tc_hold_led", {28'd0, led_out}, 32'hF);
    hold = 1'b0;
    #1;
    chk("tc_rel_tick", {31'd0, tick}, 32'd1);
    step();
    chk("tc_rel_led", {28'd0, led_out}, 32'd0);

    // Accept RUN on the terminal count while blinking
    step();
    step();
    step();
    chk("acc_pre_tick", {31'd0, tick}, 32'd1);
    cmd_valid = 1'b1;
    cmd_mode  = 2'd2;
    #1;
    chk("acc_tick_drop", {31'd0, tick}, 32'd0);
    chk("acc_ready_hi", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("acc_led", {28'd0, led_out}, 32'd1);
    chk("acc_ready_lo", {31'd0, cmd_ready}, 32'd0);
    chk("acc_t0", {31'd0, tick}, 32'd0);
    step();
    chk("acc_ready_back", {31'd0, cmd_ready}, 32'd1);
    chk("acc_t1", {31'd0, tick}, 32'd0);
    step();
    chk("acc_t2", {31'd0, tick}, 32'd0);
    step();
    chk("acc_t3", {31'd0, tick}, 32'd1);
    step();
    chk("acc_led_step", {28'd0, led_out}, 32'd2);

    // Asynchronous reset mid-BOUNCE
    issue(2'd3);
    period("rb1", 4'b0010);
    period("rb2", 4'b0100);
    step();
    sys_rst_n = 1'b0;
    #2;
    chk("arst_led", {28'd0, led_out}, 32'd0);
    chk("arst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("arst_tick", {31'd0, tick}, 32'd0);
    step();
    step();
    sys_rst_n = 1'b1;
    step();
    chk("arst_ready_hi", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      chk("post_tick", {31'd0, tick}, 32'd0);
      chk("post_led", {28'd0, led_out}, 32'd0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
